// File: rtl/pc_unit.sv
// pc_unit -- program-counter block for the MiniRISC fetch stage.
//
// Holds the registered PC and advances it each cycle by STEP, or redirects
// it by absolute jump, relative branch, call or return. Calls and returns use
// an internal circular return-address stack (RAS). A halt request freezes the
// block until reset.
//
// Parameters:
//   WIDTH     PC width in bits, all arithmetic modulo 2^WIDTH
//   STEP      sequential increment
//   RESET_PC  PC value loaded on reset
//   DEPTH     RAS entries (power of two, >= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   stall      hold all state this cycle
//   halt_req   enter HALTED state (when not stalled)
//   jmp_en     absolute jump to jmp_addr
//   jmp_addr   jump / call target
//   br_en      relative branch by br_off
//   br_off     two's-complement branch offset
//   call_en    push pc+STEP, jump to jmp_addr
//   ret_en     pop RAS into pc
//   pc         current PC (registered)
//   halted     high in HALTED state
//   ras_empty  RAS holds 0 entries
//   ras_full   RAS holds DEPTH entries
//   ras_err    sticky overflow / underflow flag
module pc_unit #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] STEP     = WIDTH'(1),
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             jmp_en,
    input  logic [WIDTH-1:0] jmp_addr,
    input  logic             br_en,
    input  logic [WIDTH-1:0] br_off,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [WIDTH-1:0] pc,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             adv_s;

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_next_s;
    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] ras_top_s;

    logic [WIDTH-1:0] ras_mem_r [DEPTH];
    logic [PW-1:0]    top_r;
    logic [PW-1:0]    top_next_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             push_s;
    logic             pop_s;
    logic             err_set_s;

    logic             err_r;
    logic             halted_r;
    logic             empty_r;
    logic             full_r;

    assign pc_inc_s  = pc_r + STEP;
    assign ras_top_s = ras_mem_r[top_r];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: HALTED is only left through reset
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt_req && !stall) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_RUN;
        endcase
    end

    // FSM output logic: the PC/RAS datapath acts only on an unstalled,
    // non-halting RUN cycle (the halting edge itself does not advance pc)
    always_comb begin
        adv_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (!stall && !halt_req) begin
                    adv_s = 1'b1;
                end else begin
                    adv_s = 1'b0;
                end
            end
            ST_HALTED: adv_s = 1'b0;
            default:   adv_s = 1'b0;
        endcase
    end

    // Next-PC selection in priority order ret > call > jmp > br > step
    always_comb begin
        pc_next_s = pc_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        err_set_s = 1'b0;
        if (adv_s) begin
            if (ret_en) begin
                if (count_r != CW'(0)) begin
                    pc_next_s = ras_top_s;
                    pop_s     = 1'b1;
                end else begin
                    // underflow: behave like a plain step and flag it
                    pc_next_s = pc_inc_s;
                    err_set_s = 1'b1;
                end
            end else if (call_en) begin
                pc_next_s = jmp_addr;
                push_s    = 1'b1;
                if (count_r == DEPTH_C) begin
                    err_set_s = 1'b1;
                end else begin
                    err_set_s = 1'b0;
                end
            end else if (jmp_en) begin
                pc_next_s = jmp_addr;
            end else if (br_en) begin
                pc_next_s = pc_r + br_off;
            end else begin
                pc_next_s = pc_inc_s;
            end
        end else begin
            pc_next_s = pc_r;
        end
    end

    // RAS pointer and occupancy update; a push into a full stack overwrites
    // the oldest slot because the pointer simply wraps round the buffer
    always_comb begin
        top_next_s   = top_r;
        count_next_s = count_r;
        if (push_s) begin
            top_next_s = top_r + PW'(1);
            if (count_r != DEPTH_C) begin
                count_next_s = count_r + CW'(1);
            end else begin
                count_next_s = count_r;
            end
        end else if (pop_s) begin
            top_next_s   = top_r - PW'(1);
            count_next_s = count_r - CW'(1);
        end else begin
            top_next_s   = top_r;
            count_next_s = count_r;
        end
    end

    // PC, RAS bookkeeping and status flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            top_r    <= '0;
            count_r  <= '0;
            err_r    <= 1'b0;
            halted_r <= 1'b0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            pc_r     <= pc_next_s;
            top_r    <= top_next_s;
            count_r  <= count_next_s;
            err_r    <= err_r | err_set_s;
            halted_r <= (state_next_s == ST_HALTED);
            empty_r  <= (count_next_s == CW'(0));
            full_r   <= (count_next_s == DEPTH_C);
        end
    end

    // RAS storage; contents need no reset since occupancy is cleared
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            ras_mem_r[top_next_s] <= pc_inc_s;
        end
    end

    assign pc        = pc_r;
    assign halted    = halted_r;
    assign ras_empty = empty_r;
    assign ras_full  = full_r;
    assign ras_err   = err_r;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- self-checking bench for pc_unit.
// Instance a: WIDTH=16, RESET_PC=0x100, DEPTH=4 (directed table + random vs model).
// Instance b: WIDTH=8, RESET_PC=0, DEPTH=2 (wrap-around and short-offset cases).
module tb_pc_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance a
    logic        a_rst, a_stall, a_halt, a_jmp, a_br, a_call, a_ret;
    logic [15:0] a_addr, a_off;
    logic [15:0] a_pc;
    logic        a_halted, a_empty, a_full, a_err;

    // instance b
    logic        b_rst, b_stall, b_halt, b_jmp, b_br, b_call, b_ret;
    logic [7:0]  b_addr, b_off;
    logic [7:0]  b_pc;
    logic        b_halted, b_empty, b_full, b_err;

    pc_unit #(.WIDTH(16), .STEP(16'h0001), .RESET_PC(16'h0100), .DEPTH(4)) dut_a (
        .clk(clk), .rst(a_rst), .stall(a_stall), .halt_req(a_halt),
        .jmp_en(a_jmp), .jmp_addr(a_addr), .br_en(a_br), .br_off(a_off),
        .call_en(a_call), .ret_en(a_ret), .pc(a_pc), .halted(a_halted),
        .ras_empty(a_empty), .ras_full(a_full), .ras_err(a_err)
    );

    pc_unit #(.WIDTH(8), .STEP(8'h01), .RESET_PC(8'h00), .DEPTH(2)) dut_b (
        .clk(clk), .rst(b_rst), .stall(b_stall), .halt_req(b_halt),
        .jmp_en(b_jmp), .jmp_addr(b_addr), .br_en(b_br), .br_off(b_off),
        .call_en(b_call), .ret_en(b_ret), .pc(b_pc), .halted(b_halted),
        .ras_empty(b_empty), .ras_full(b_full), .ras_err(b_err)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        stall, halt, jmp;
        logic [15:0] addr;
        logic        br;
        logic [15:0] off;
        logic        call, ret;
        logic [15:0] pc;
        logic        empty, full, err, halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic h, input logic j,
                                input logic [15:0] a, input logic b, input logic [15:0] o,
                                input logic c, input logic r, input logic [15:0] p,
                                input logic e, input logic f, input logic er, input logic hl);
        vec_t v;
        v.stall = s; v.halt = h; v.jmp = j; v.addr = a; v.br = b; v.off = o;
        v.call = c; v.ret = r; v.pc = p; v.empty = e; v.full = f; v.err = er; v.halted = hl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_stall = 1'b0; a_halt = 1'b0; a_jmp = 1'b0; a_br = 1'b0;
        a_call = 1'b0; a_ret = 1'b0; a_addr = 16'h0000; a_off = 16'h0000;
    endtask

    task automatic b_idle();
        b_stall = 1'b0; b_halt = 1'b0; b_jmp = 1'b0; b_br = 1'b0;
        b_call = 1'b0; b_ret = 1'b0; b_addr = 8'h00; b_off = 8'h00;
    endtask

    // behavioural reference for instance a
    logic [15:0] m_pc;
    logic [15:0] m_q[$];
    logic        m_err, m_halted;

    task automatic model_step(input logic rst, input logic s, input logic h, input logic j,
                              input logic [15:0] a, input logic b, input logic [15:0] o,
                              input logic c, input logic r);
        if (rst) begin
            m_pc = 16'h0100; m_q.delete(); m_err = 1'b0; m_halted = 1'b0;
        end else if (m_halted || s) begin
            // frozen
        end else if (h) begin
            m_halted = 1'b1;
        end else if (r) begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else begin m_pc = m_pc + 16'd1; m_err = 1'b1; end
        end else if (c) begin
            if (m_q.size() == 4) begin void'(m_q.pop_front()); m_err = 1'b1; end
            m_q.push_back(m_pc + 16'd1);
            m_pc = a;
        end else if (j) begin
            m_pc = a;
        end else if (b) begin
            m_pc = m_pc + o;
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_idle(); b_idle();

        // ---------------- directed table on instance a ----------------
        //             s    h    j    addr      b    off       c    r    pc        e    f    err  hlt
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0101,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0102,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0103,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0010,1'b0,16'h0000,1'b0,1'b0,16'h0010,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0080,1'b0,16'h0000,1'b1,1'b0,16'h0080,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0081,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0082,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,16'h0011,1'b1,1'b0,1'b0,1'b0));
        // five calls overflow a 4-deep stack
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0020,1'b0,16'h0000,1'b0,1'b0,16'h0020,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0040,1'b0,16'h0000,1'b1,1'b0,16'h0040,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0060,1'b0,16'h0000,1'b1,1'b0,16'h0060,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0080,1'b0,16'h0000,1'b1,1'b0,16'h0080,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h00A0,1'b0,16'h0000,1'b1,1'b0,16'h00A0,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h00C0,1'b0,16'h0000,1'b1,1'b0,16'h00C0,1'b0,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,16'h00A1,1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,16'h0081,1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,16'h0061,1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,16'h0041,1'b1,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,16'h0042,1'b1,1'b0,1'b1,1'b0));
        // ret beats call and jmp with one entry (0x33) on the stack
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0032,1'b0,16'h0000,1'b0,1'b0,16'h0032,1'b1,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0050,1'b0,16'h0000,1'b1,1'b0,16'h0050,1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b1,16'h0099,1'b0,16'h0000,1'b1,1'b1,16'h0033,1'b1,1'b0,1'b1,1'b0));
        // branches, negative then positive
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1,16'hFFFE,1'b0,1'b0,16'h0031,1'b1,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1,16'h0010,1'b0,1'b0,16'h0041,1'b1,1'b0,1'b1,1'b0));
        // stall masks call and halt, then halt freezes everything
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0070,1'b0,16'h0000,1'b1,1'b0,16'h0070,1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,16'h0090,1'b0,16'h0000,1'b1,1'b0,16'h0070,1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,16'h0090,1'b0,16'h0000,1'b1,1'b0,16'h0070,1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,16'h0090,1'b0,16'h0000,1'b1,1'b0,16'h0070,1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0070,1'b0,1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0090,1'b0,16'h0000,1'b1,1'b0,16'h0070,1'b0,1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b1,16'h0070,1'b0,1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0070,1'b0,1'b0,1'b1,1'b1));

        tick();
        chk("a_reset", {a_pc, a_empty, a_full, a_err, a_halted}, {16'h0100, 1'b1, 1'b0, 1'b0, 1'b0});
        a_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            a_stall = vecs[i].stall; a_halt = vecs[i].halt; a_jmp = vecs[i].jmp;
            a_addr = vecs[i].addr; a_br = vecs[i].br; a_off = vecs[i].off;
            a_call = vecs[i].call; a_ret = vecs[i].ret;
            tick();
            chk($sformatf("a_vec%0d", i), {a_pc, a_empty, a_full, a_err, a_halted},
                {vecs[i].pc, vecs[i].empty, vecs[i].full, vecs[i].err, vecs[i].halted});
        end

        // reset exits HALTED and clears the stack and sticky error
        a_idle(); a_rst = 1'b1;
        tick();
        chk("a_reset_from_halt", {a_pc, a_empty, a_full, a_err, a_halted},
            {16'h0100, 1'b1, 1'b0, 1'b0, 1'b0});

        // ---------------- instance b: 8-bit wrap cases ----------------
        b_idle(); b_rst = 1'b0;
        b_jmp = 1'b1; b_addr = 8'hFF; tick();
        chk("b_jmp_ff", {56'd0, b_pc}, {56'd0, 8'hFF});
        b_idle(); tick();
        chk("b_wrap", {56'd0, b_pc}, {56'd0, 8'h00});
        b_jmp = 1'b1; b_addr = 8'h05; tick();
        b_idle(); b_br = 1'b1; b_off = 8'hFE; tick();
        chk("b_br_neg", {56'd0, b_pc}, {56'd0, 8'h03});
        b_idle(); b_jmp = 1'b1; b_addr = 8'hFF; tick();
        b_idle(); b_call = 1'b1; b_addr = 8'h10; tick();
        chk("b_call_from_ff", {b_pc, b_empty}, {8'h10, 1'b0});
        b_idle(); b_ret = 1'b1; tick();
        chk("b_ret_wrapped", {b_pc, b_empty, b_err}, {8'h00, 1'b1, 1'b0});
        b_idle(); b_call = 1'b1; b_addr = 8'h20; tick();
        b_addr = 8'h30; tick();
        chk("b_full", {b_pc, b_full, b_err}, {8'h30, 1'b1, 1'b0});
        b_idle();

        // ---------------- instance a: random vs reference model ----------------
        for (int i = 0; i < 600; i++) begin
            a_rst   = (i == 0) || ($urandom_range(59, 0) == 0);
            a_stall = ($urandom_range(5, 0) == 0);
            a_halt  = ($urandom_range(39, 0) == 0);
            a_ret   = ($urandom_range(4, 0) == 0);
            a_call  = ($urandom_range(4, 0) == 0);
            a_jmp   = ($urandom_range(5, 0) == 0);
            a_br    = ($urandom_range(3, 0) == 0);
            a_addr  = 16'($urandom);
            a_off   = 16'($urandom);
            model_step(a_rst, a_stall, a_halt, a_jmp, a_addr, a_br, a_off, a_call, a_ret);
            tick();
            chk($sformatf("a_rand%0d", i), {a_pc, a_empty, a_full, a_err, a_halted},
                {m_pc, (m_q.size() == 0), (m_q.size() == 4), m_err, m_halted});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
